// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM states,
// architectural constants and a PC-to-word-index helper.
package rv_fetch_pkg;

  localparam int XLEN = 32;

  // Canonical no-op (addi x0, x0, 0), available to any stage that needs a bubble.
  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

  // Byte distance between consecutive 32-bit instructions.
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // Word index of a byte PC; the low two bits are dropped.
  function automatic logic [XLEN-1:0] pc_to_word(input logic [XLEN-1:0] pc);
    return pc >> 2;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous fetch buffer holding {pc, inst} pairs. The head is
// visible combinationally so a word pushed at an edge is presented in the
// following cycle. Flush empties the buffer in one edge.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2 * XLEN,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Entry storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational
// instruction memory, buffers words and hands them to decode. Handles
// branch/jump redirects (with flush) and halts once the PC leaves memory.
module fetch_ctrl
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 32,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  output logic        im_en,
  input  logic [31:0] im_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        halted
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e      state_q;
  logic [XLEN-1:0]   pc_q;
  logic              halted_q;

  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [2*XLEN-1:0] fifo_head;
  logic              fifo_full;
  logic              in_range;
  logic              redirect_take;
  logic              pop_req;
  logic              pop;
  logic              push_ok;

  // Redirects are ignored during the single post-reset IDLE cycle.
  assign redirect_take = redirect_valid && (state_q != ST_IDLE);
  assign in_range      = (pc_to_word(pc_q) < XLEN'(IMEM_DEPTH));
  assign fifo_full     = (fifo_count == CNT_W'(FIFO_DEPTH));

  // A full buffer can still accept a word when its head leaves this cycle.
  assign pop_req = !fifo_empty && if_ready;
  assign push_ok = !fifo_full || pop_req;
  // A redirect kills the head handshake: the flushed entry is not consumed.
  assign pop     = pop_req && !redirect_take;

  assign im_en   = (state_q == ST_FETCH) && in_range && push_ok && !redirect_take;
  assign im_addr = (state_q == ST_FETCH) ? pc_to_word(pc_q) : '0;

  assign if_valid = !fifo_empty;
  assign if_inst  = fifo_empty ? '0 : fifo_head[XLEN-1:0];
  assign if_pc    = fifo_empty ? '0 : fifo_head[2*XLEN-1:XLEN];
  assign halted   = halted_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst_n_i (rst_n),
    .push_i  (im_en),
    .pop_i   (pop),
    .flush_i (redirect_take),
    .wdata_i ({pc_q, im_data}),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Fetch FSM and PC: reset beats redirect, redirect beats normal sequencing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else if (redirect_take) begin
      state_q  <= ST_FETCH;
      pc_q     <= redirect_pc & ~32'h3;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (!in_range) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (im_en) begin
            pc_q <= pc_q + PC_STEP;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed walk through the fetch scenarios, then
// randomized traffic, all scored against a queue-based reference model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr;
  logic        im_en;
  logic [31:0] im_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        halted;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC   (32'h0),
    .IMEM_DEPTH (32),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_addr        (im_addr),
    .im_en          (im_en),
    .im_data        (im_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .halted         (halted)
  );

  // Instruction memory image, read combinationally.
  logic [31:0] imem [32];
  always_comb begin
    im_data = 32'h0;
    if (im_addr < 32) im_data = imem[im_addr[4:0]];
  end

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: buffered {pc, inst} pairs plus fetch PC and mode flags.
  logic [63:0] q[$];
  logic [31:0] m_pc;
  bit          m_idle;
  bit          m_halted;
  bit          m_known;

  // Values sampled in the most recent step.
  logic        s_valid, s_en, s_halted;
  logic [31:0] s_pc, s_inst, s_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rp);
    bit          e_valid, pop, redir, in_rng, e_en;
    logic [31:0] e_pc, e_inst;
    rst_n          = r;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    @(negedge clk);
    e_valid = (q.size() != 0);
    e_pc    = e_valid ? q[0][63:32] : 32'h0;
    e_inst  = e_valid ? q[0][31:0]  : 32'h0;
    redir   = rv && !m_idle;
    pop     = e_valid && rdy && !redir;
    in_rng  = (m_pc >> 2) < 32;
    e_en    = !m_idle && !m_halted && !redir && in_rng && (q.size() < 2 || (e_valid && rdy));
    s_valid = if_valid; s_pc = if_pc; s_inst = if_inst;
    s_en = im_en; s_addr = im_addr; s_halted = halted;
    if (m_known) begin
      chk("if_valid", {31'b0, if_valid}, {31'b0, e_valid});
      chk("if_pc", if_pc, e_pc);
      chk("if_inst", if_inst, e_inst);
      chk("halted", {31'b0, halted}, {31'b0, m_halted});
      chk("im_en", {31'b0, im_en}, {31'b0, e_en});
      if (e_en) chk("im_addr", im_addr, m_pc >> 2);
    end
    @(posedge clk);
    if (!r) begin
      q.delete(); m_pc = 32'h0; m_idle = 1; m_halted = 0; m_known = 1;
    end else if (redir) begin
      q.delete(); m_pc = rp & ~32'h3; m_halted = 0;
    end else if (m_idle) begin
      m_idle = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (e_en) begin
        q.push_back({m_pc, imem[m_pc[6:2]]});
        m_pc = m_pc + 32'd4;
      end
      if (!m_halted && !in_rng) m_halted = 1;
    end
    #1;
  endtask

  initial begin
    logic [31:0] last_pc;
    m_known = 0; m_idle = 1; m_halted = 0; m_pc = 0;
    rst_n = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 32; i++) imem[i] = $urandom;
    imem[0]  = 32'h0000_0000;
    imem[1]  = 32'h0210_0AB3;   // MUL
    imem[18] = 32'h0030_8093;   // ADDI
    imem[31] = 32'h0000_0097;   // AUIPC

    // Reset, then stream with decode always ready.
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("idle_en", {31'b0, s_en}, 32'h0);
    chk("idle_addr", s_addr, 32'h0);
    step(1, 1, 0, 0);
    chk("first_fetch_en", {31'b0, s_en}, 32'h1);
    chk("first_fetch_valid", {31'b0, s_valid}, 32'h0);
    step(1, 1, 0, 0);
    chk("head0_pc", s_pc, 32'h0);
    chk("head0_inst", s_inst, 32'h0);
    step(1, 1, 0, 0);
    chk("head1_pc", s_pc, 32'h4);
    chk("head1_inst", s_inst, 32'h0210_0AB3);

    // Decode stalled from reset: buffer fills, fetch holds at pc 0x8.
    step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    chk("stall_en", {31'b0, s_en}, 32'h0);
    chk("stall_addr", s_addr, 32'h2);
    step(1, 1, 0, 0); chk("resume_pc0", s_pc, 32'h0);
    step(1, 1, 0, 0); chk("resume_pc4", s_pc, 32'h4);
    step(1, 1, 0, 0); chk("resume_pc8", s_pc, 32'h8);

    // Mid-stream redirect to an unaligned target.
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 1, 32'h4B);
    step(1, 1, 0, 0);
    chk("redir_gap_valid", {31'b0, s_valid}, 32'h0);
    chk("redir_fetch_addr", s_addr, 32'h12);
    step(1, 1, 0, 0);
    chk("redir_head_pc", s_pc, 32'h48);
    chk("redir_head_inst", s_inst, 32'h0030_8093);

    // Free-run off the end of memory.
    last_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 60; i++) begin
      step(1, 1, 0, 0);
      if (s_valid) last_pc = s_pc;
      if (s_halted) break;
    end
    chk("last_pc", last_pc, 32'h7C);
    chk("halt_seen", {31'b0, s_halted}, 32'h1);
    step(1, 1, 0, 0);
    chk("halt_en", {31'b0, s_en}, 32'h0);
    step(1, 1, 1, 32'h0);
    step(1, 1, 0, 0);
    chk("unhalt", {31'b0, s_halted}, 32'h0);
    chk("unhalt_en", {31'b0, s_en}, 32'h1);
    chk("unhalt_addr", s_addr, 32'h0);

    // Full buffer with decode ready: push and pop every cycle.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      chk("full_push_en", {31'b0, s_en}, 32'h1);
      chk("full_pop_valid", {31'b0, s_valid}, 32'h1);
    end
    step(1, 1, 1, 32'h10);
    step(1, 1, 0, 0);
    chk("flush_empty", {31'b0, s_valid}, 32'h0);

    // Single-edge reset while streaming.
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("rst_valid", {31'b0, s_valid}, 32'h0);
    chk("rst_pc", s_pc, 32'h0);
    chk("rst_inst", s_inst, 32'h0);
    chk("rst_en", {31'b0, s_en}, 32'h0);
    chk("rst_addr", s_addr, 32'h0);
    chk("rst_halted", {31'b0, s_halted}, 32'h0);
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    chk("rst_restart_pc", s_pc, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic r, rdy, rv;
      r   = ($urandom_range(0, 99) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      step(r, rdy, rv, $urandom_range(0, 32'h9F));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
